cpu_ctrl_seq: RTL
=================

Name: cpu_ctrl_seq

Overview:
Instruction sequencer for the 18-bit accumulator CPU. It drives the one-hot read/write enables of the accumulator/IR register block, the program counter and the synchronous memory. It consumes the registered opcode and the I/O flags that the register block produces. It implements fetch, decode and execute with I/O wait handshakes and a timeout.

Parameters:
IO_TIMEOUT, 255, max cycles to wait on I_flag/O_flag before the instruction is abandoned
TO_W, 8, width of the timeout counter; must hold IO_TIMEOUT

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
run  input  1  level; 1 = fetch new instructions, 0 = stop at the next instruction boundary
opcode  input  3  registered opcode from the register block
I_flag  input  1  1 = input register holds nonzero data
O_flag  input  1  1 = output register is empty
read_inpr_en, write_outr_en, read_ac_en, write_ac_en, read_ir_en, write_ir_en  output  1 each  register-block enables, at most one high per cycle
mem_rd  output  1  synchronous memory read; data valid the next cycle
mem_wr  output  1  memory write of register-block out_data
addr_sel  output  1  memory address source: 0 = PC, 1 = IR[14:0]
pc_inc  output  1  PC <= PC+1 (18-bit wrap)
pc_load  output  1  PC <= IR[14:0]
alu_en  output  1  ALU latches out_data and memory data
alu_op  output  1  0 = ADD, 1 = AND
in_sel  output  2  register-block in_data mux: 0 = memory, 1 = ALU result, 2 = out_data loopback
instr_done  output  1  one-cycle pulse when an instruction retires
io_timeout  output  1  one-cycle pulse when an I/O wait expires
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async): state IDLE, all outputs 0, in_sel = 0, addr_sel = 0, timeout counter 0, latched opcode 0.
- All outputs are Moore, decoded from the registered state. Every enable not listed for a state is 0.
- IDLE: go to F0 when run = 1.
- F0: mem_rd = 1, addr_sel = 0.
- F1: write_ir_en = 1, in_sel = 0, pc_inc = 1.
- D0: wait one cycle while IR settles.
- D1: wait one cycle while the register block re-registers opcode from IR; latch opcode into the internal op register at the end of D1.
- Execute by op:
  - 0 NOP: E0 (instr_done).
  - 1 LDA:
    - E0: mem_rd, addr_sel = 1.
    - E1: write_ac_en, in_sel = 0, instr_done.
  - 2 STA:
    - E0: read_ac_en.
    - E1: mem_wr, addr_sel = 1, instr_done.
  - 3 ADD / 4 AND:
    - E0: read_ac_en, mem_rd, addr_sel = 1.
    - E1: alu_en, alu_op = (op == 4).
    - E2: write_ac_en, in_sel = 1, instr_done.
  - 5 JMP: E0: pc_load, instr_done.
  - 6 INP:
    - WAIT_I: stay while I_flag = 0, incrementing the counter.
    - When I_flag = 1: E0 read_inpr_en, then E1 write_ac_en, in_sel = 2, instr_done.
  - 7 OUT:
    - WAIT_O: wait on O_flag = 1 the same way.
    - Then E0 read_ac_en, then E1 write_outr_en, in_sel = 2, instr_done.
- Timeout:
  - The counter clears on entry to WAIT_I/WAIT_O.
  - When the counter equals IO_TIMEOUT with the flag still low: pulse io_timeout, no register-block enable, skip to the boundary.
  - A flag arriving in the same cycle as the counter reaching IO_TIMEOUT wins: no timeout.
- Boundary (after instr_done or io_timeout): go to F0 if run = 1, else IDLE. run is ignored mid-instruction.
- Instruction latencies in cycles from F0:
  - NOP 5, JMP 5.
  - LDA 6, STA 6.
  - ADD 7, AND 7.
  - INP and OUT: 6 + wait cycles.
- Reset asserted mid-instruction aborts immediately; no partial memory write completes after rst rises.

Test Plan:
- Reset mid-ADD (assert rst during E1) -> all enables 0 asynchronously; with run held high after release, IDLE→F0 on the first clock.
- run = 1, memory word 0 = LDA 0x10, mem[0x10] = 5 -> F0 mem_rd addr_sel = 0; F1 write_ir_en + pc_inc; E0 mem_rd addr_sel = 1; E1 write_ac_en in_sel = 0; instr_done at cycle 6.
- ADD with AC = 54, mem = 10 -> E0 read_ac_en + mem_rd; E1 alu_en alu_op = 0; E2 write_ac_en in_sel = 1; instr_done at cycle 7; AND gives alu_op = 1.
- INP with I_flag held 0 for 3 cycles then 1 -> 3 WAIT_I cycles, then read_inpr_en, then write_ac_en in_sel = 2; io_timeout stays 0.
- OUT with O_flag stuck 0, IO_TIMEOUT = 4 -> io_timeout pulses once after 4 waits; write_outr_en never asserted; next F0 follows.
- run dropped during E0 of JMP -> pc_load and instr_done still occur, then IDLE; busy = 0.
- Every cycle of every test -> at most one of the six register-block enables high.

Source files
------------

// File: rtl/cpu_ctrl_seq.sv
// Purpose : fetch/decode/execute sequencer for the 18-bit accumulator CPU; drives
//           register-block enables, PC control and synchronous memory strobes.
// Latency : NOP/JMP 5, LDA/STA 6, ADD/AND 7, INP/OUT 6 + wait cycles (from F0).
// Backpressure: I/O ops stall in a wait state on I_flag/O_flag, abandoned after IO_TIMEOUT waits.
//
// Ports: clk/rst (async, active high); run (stop at instruction boundary when low);
//        opcode, I_flag, O_flag from the register block; one-hot register-block
//        enables; mem_rd/mem_wr/addr_sel; pc_inc/pc_load; alu_en/alu_op; in_sel;
//        instr_done / io_timeout pulses; busy (high outside IDLE).
module cpu_ctrl_seq #(
    parameter int IO_TIMEOUT = 255,
    parameter int TO_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [2:0] opcode,
    input  logic       I_flag,
    input  logic       O_flag,
    output logic       read_inpr_en,
    output logic       write_outr_en,
    output logic       read_ac_en,
    output logic       write_ac_en,
    output logic       read_ir_en,
    output logic       write_ir_en,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       addr_sel,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       alu_en,
    output logic       alu_op,
    output logic [1:0] in_sel,
    output logic       instr_done,
    output logic       io_timeout,
    output logic       busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_F0, S_F1, S_D0, S_D1,
        S_WAIT_I, S_WAIT_O, S_TMO,
        S_E0, S_E1, S_E2
    } state_t;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_LDA = 3'd1;
    localparam logic [2:0] OP_STA = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_JMP = 3'd5;
    localparam logic [2:0] OP_INP = 3'd6;
    localparam logic [2:0] OP_OUT = 3'd7;

    localparam logic [TO_W:0] TO_LIM = (TO_W+1)'(IO_TIMEOUT);

    state_t          state, next;
    logic [2:0]      op;
    logic [TO_W-1:0] cnt;
    logic            last;
    logic            timeout_hit;

    // The wait that brings the counter up to IO_TIMEOUT is the last one; a flag
    // seen in that same cycle still takes the E0 branch because it is tested first.
    assign timeout_hit = (({1'b0, cnt} + (TO_W+1)'(1)) == TO_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            op    <= 3'd0;
            cnt   <= '0;
        end else begin
            state <= next;
            if (state == S_D1)
                op <= opcode;
            // Counter is zero whenever a wait state is entered; it only runs inside one.
            if (state == S_WAIT_I || state == S_WAIT_O)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
        end
    end

    always_comb begin
        next = state;
        last = 1'b0;
        case (state)
            S_IDLE: if (run) next = S_F0;
            S_F0:   next = S_F1;
            S_F1:   next = S_D0;
            S_D0:   next = S_D1;
            // op is only latched at the end of D1, so branch on the live opcode here.
            S_D1: begin
                case (opcode)
                    OP_INP:  next = I_flag ? S_E0 : S_WAIT_I;
                    OP_OUT:  next = O_flag ? S_E0 : S_WAIT_O;
                    default: next = S_E0;
                endcase
            end
            S_WAIT_I: begin
                if (I_flag)           next = S_E0;
                else if (timeout_hit) next = S_TMO;
            end
            S_WAIT_O: begin
                if (O_flag)           next = S_E0;
                else if (timeout_hit) next = S_TMO;
            end
            S_TMO: last = 1'b1;
            S_E0: begin
                if (op == OP_NOP || op == OP_JMP) last = 1'b1;
                else                               next = S_E1;
            end
            S_E1: begin
                if (op == OP_ADD || op == OP_AND) next = S_E2;
                else                               last = 1'b1;
            end
            S_E2:    last = 1'b1;
            default: next = S_IDLE;
        endcase
        // run is only looked at on an instruction boundary.
        if (last)
            next = run ? S_F0 : S_IDLE;
    end

    always_comb begin
        read_inpr_en  = 1'b0;
        write_outr_en = 1'b0;
        read_ac_en    = 1'b0;
        write_ac_en   = 1'b0;
        read_ir_en    = 1'b0;
        write_ir_en   = 1'b0;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        addr_sel      = 1'b0;
        pc_inc        = 1'b0;
        pc_load       = 1'b0;
        alu_en        = 1'b0;
        alu_op        = 1'b0;
        in_sel        = 2'd0;
        instr_done    = 1'b0;
        io_timeout    = 1'b0;
        busy          = (state != S_IDLE);
        case (state)
            S_F0: mem_rd = 1'b1;
            S_F1: begin
                write_ir_en = 1'b1;
                pc_inc      = 1'b1;
            end
            S_TMO: io_timeout = 1'b1;
            S_E0: begin
                case (op)
                    OP_NOP: instr_done = 1'b1;
                    OP_LDA: begin
                        mem_rd   = 1'b1;
                        addr_sel = 1'b1;
                    end
                    OP_STA: read_ac_en = 1'b1;
                    OP_ADD, OP_AND: begin
                        read_ac_en = 1'b1;
                        mem_rd     = 1'b1;
                        addr_sel   = 1'b1;
                    end
                    OP_JMP: begin
                        pc_load    = 1'b1;
                        instr_done = 1'b1;
                    end
                    OP_INP:  read_inpr_en = 1'b1;
                    default: read_ac_en   = 1'b1;
                endcase
            end
            S_E1: begin
                case (op)
                    OP_LDA: begin
                        write_ac_en = 1'b1;
                        instr_done  = 1'b1;
                    end
                    OP_STA: begin
                        mem_wr     = 1'b1;
                        addr_sel   = 1'b1;
                        instr_done = 1'b1;
                    end
                    OP_ADD, OP_AND: begin
                        alu_en = 1'b1;
                        alu_op = (op == OP_AND);
                    end
                    OP_INP: begin
                        write_ac_en = 1'b1;
                        in_sel      = 2'd2;
                        instr_done  = 1'b1;
                    end
                    OP_OUT: begin
                        write_outr_en = 1'b1;
                        in_sel        = 2'd2;
                        instr_done    = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_E2: begin
                write_ac_en = 1'b1;
                in_sel      = 2'd1;
                instr_done  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
